hd_arb: RTL and testbench
=========================

# hd_arb

Round-robin arbiter and sequencer sharing one Hamming decoder pipeline (`hd_top`) between `NREQ` requesters. It accepts codewords over per-requester valid/ready handshakes and launches at most one codeword per cycle into the decoder. A tag pipeline matched to the decoder latency routes each corrected data word back to the requester that issued it. A drain FSM quiesces the decoder for reconfiguration or power-down.

## Interface
Parameters:
- `K`, 8, data width; passed to `hd_top`.
- `M`, derived localparam, parity width; uses the same K→M table as `hd_top` (K=8 → M=4).
- `NREQ`, 4, number of requesters, 2..16.
- `LAT`, 4, decoder latency in cycles from `hd_cvld` to `hd_dvld`.
- `TW`, derived localparam, tag width = clog2(NREQ).

Ports (clock and reset first):
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_vld`  in  NREQ  per-requester codeword valid.
- `req_rdy`  out  NREQ  per-requester grant, one-hot or zero.
- `req_cw`  in  NREQ*(K+M)  codewords; requester i occupies bits [i*(K+M) +: K+M].
- `hd_cin`  out  K+M  codeword to the decoder; registered.
- `hd_cvld`  out  1  codeword valid to the decoder; registered.
- `hd_dout`  in  K  corrected data from the decoder.
- `hd_dvld`  in  1  data valid from the decoder.
- `rsp_vld`  out  NREQ  one-hot response strobe.
- `rsp_data`  out  K  shared response data bus, equal to `hd_dout`.
- `drain`  in  1  request to stop issuing and empty the pipeline.
- `idle`  out  1  high in IDLE state.
- `seq_err`  out  1  sticky; set on a tag/`hd_dvld` mismatch.

## Operation
- A transfer on requester i occurs when `req_vld[i] & req_rdy[i]`.
- Arbitration:
  - `req_rdy` is combinational from `req_vld`, `ptr` and state.
  - The grant goes to the first asserted `req_vld` searching i = ptr, ptr+1, … mod NREQ.
  - Grants are issued only when state = RUN and `drain` = 0.
  - After a grant to i, `ptr` ← (i+1) mod NREQ. With no grant, `ptr` holds.
- Launch: on a transfer, next cycle `hd_cin` = `req_cw[i]` and `hd_cvld` = 1. Otherwise `hd_cvld` = 0 and `hd_cin` holds.
- Tag pipeline:
  - LAT stages of {valid, tag}.
  - Stage 0 loads {`hd_cvld`, launched index} each cycle.
  - Stage LAT-1 output is the response tag.
- Response, combinational:
  - `rsp_vld[t]` = `tagvld_out` & (t == `tag_out`).
  - `rsp_data` = `hd_dout`.
  - Responses have no backpressure; requesters must sink a strobe every cycle.
- In-flight counter, width clog2(LAT+2):
  - +1 on launch, −1 when `tagvld_out`; both in the same cycle leaves it unchanged.
  - Never exceeds LAT+1.
- FSM {RUN, DRAIN, IDLE}:
  - RUN → DRAIN when `drain` = 1.
  - DRAIN → IDLE when in-flight = 0 and `hd_cvld` = 0.
  - DRAIN → RUN when `drain` = 0 before empty.
  - IDLE → RUN when `drain` = 0.
  - `drain` gates grants combinationally in the same cycle it rises.
- Error check:
  - `seq_err` is set when `hd_dvld` != `tagvld_out`.
  - The check is masked for the first LAT+1 cycles after reset release, because decoder `hd_dvld` may be unknown there.
  - `seq_err` clears only on reset.

## Timing
- Reset values:
  - `req_rdy` = 0 while in reset.
  - `hd_cin` = 0, `hd_cvld` = 0, `rsp_vld` = 0.
  - `idle` = 0, `seq_err` = 0.
  - state = RUN, `ptr` = 0, tag pipeline cleared, in-flight = 0.
- Latency: a transfer at cycle n gives `hd_cvld` at n+1 and `rsp_vld` at n+1+LAT (n+5 by default).
- Throughput: one codeword per cycle aggregate; each requester is served at least once every NREQ grants.
- Reset mid-operation clears all in-flight tags. Responses that later emerge from the decoder are ignored, and the `seq_err` mask covers this window.
- `idle` asserts the cycle after the last response strobe (registered state).

## Configuration
- `HD_ARB_STATS_EN`:
  - Defined: adds output `stat_cnt` [15:0], counting responses (`tagvld_out`). It saturates at 16'hFFFF, resets to 0, and is also cleared on the IDLE→RUN transition.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Single requester: reset, `req_vld[2]`=1 for one cycle with `req_cw[2]`=12'h0A5 → `req_rdy`=4'b0100 the same cycle; `hd_cvld`=1 with `hd_cin`=12'h0A5 next cycle; `rsp_vld`=4'b0100 five cycles after the transfer.
- All four requesters held valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses return in that order at one per cycle; in-flight peaks at 5.
- Fairness: `req_vld`=4'b1001 continuously → grants alternate 0,3,0,3; requesters 1 and 2 get none.
- Drain: assert `drain` with 3 words in flight → `req_rdy`=0 immediately; 3 responses still delivered; `idle`=1 one cycle after the last; deassert `drain` → grants resume from `ptr`.
- Mismatch: after warm-up, force `hd_dvld`=1 with an empty tag pipeline → `seq_err`=1 and stays set until `rst`=0.
- Reset mid-stream: pulse `rst` low with 4 words in flight → all outputs return to reset values; no `rsp_vld` after release; `seq_err` stays 0.

Source files
------------

// File: rtl/hd_arb.sv
// hd_arb: round-robin arbiter and sequencer sharing one Hamming decoder pipeline between NREQ requesters.
// Define HD_ARB_STATS_EN to add the saturating response counter output stat_cnt.
module hd_arb #(
    parameter  int K    = 8,
    parameter  int NREQ = 4,
    parameter  int LAT  = 4,
    localparam int M    = (K <= 1)  ? 2 : (K <= 4)  ? 3 : (K <= 11)  ? 4 :
                          (K <= 26) ? 5 : (K <= 57) ? 6 : (K <= 120) ? 7 : 8,
    localparam int TW   = $clog2(NREQ),
    localparam int CW   = K + M
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ*CW-1:0]   req_cw,
    output logic [CW-1:0]        hd_cin,
    output logic                 hd_cvld,
    input  logic [K-1:0]         hd_dout,
    input  logic                 hd_dvld,
    output logic [NREQ-1:0]      rsp_vld,
    output logic [K-1:0]         rsp_data,
    input  logic                 drain,
    output logic                 idle,
    output logic                 seq_err
`ifdef HD_ARB_STATS_EN
    ,
    output logic [15:0]          stat_cnt
`endif
);
    localparam int IW = $clog2(LAT + 2);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_IDLE} state_t;
    state_t state, state_nxt;

    logic [TW-1:0]  ptr;
    logic [TW-1:0]  gnt_idx;
    logic           gnt_found;
    logic [TW:0]    cand;
    logic           gnt_en;
    logic           xfer;
    logic [CW-1:0]  cw_arr [NREQ];
    logic [TW-1:0]  cin_tag;
    logic [LAT-1:0] vld_pipe;
    logic [TW-1:0]  tag_pipe [LAT];
    logic           tagvld_out;
    logic [TW-1:0]  tag_out;
    logic [IW-1:0]  inflight, inflight_nxt;
    logic [IW-1:0]  mask_cnt;
    logic           chk_en;

    for (genvar i = 0; i < NREQ; i++) begin : g_cw
        assign cw_arr[i] = req_cw[i*CW +: CW];
    end

    // Rotating search starting at ptr; first asserted valid wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (TW+1)'(k);
            if (cand >= (TW+1)'(NREQ))
                cand = cand - (TW+1)'(NREQ);
            if (!gnt_found && req_vld[cand[TW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[TW-1:0];
            end
        end
    end

    // rst gates grants directly so req_rdy is low for the whole reset window.
    assign gnt_en = rst && (state == S_RUN) && !drain;
    assign xfer   = gnt_en && gnt_found;

    always_comb begin
        req_rdy = '0;
        if (xfer)
            req_rdy[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            hd_cin  <= '0;
            hd_cvld <= 1'b0;
            cin_tag <= '0;
        end else begin
            hd_cvld <= xfer;
            if (xfer) begin
                hd_cin  <= cw_arr[gnt_idx];
                cin_tag <= gnt_idx;
                ptr     <= (gnt_idx == TW'(NREQ-1)) ? '0 : gnt_idx + TW'(1);
            end
        end
    end

    // Tag pipeline mirrors the decoder latency so tags line up with hd_dvld.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            for (int s = 0; s < LAT; s++)
                tag_pipe[s] <= '0;
        end else begin
            vld_pipe[0] <= hd_cvld;
            tag_pipe[0] <= cin_tag;
            for (int s = 1; s < LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign tagvld_out = vld_pipe[LAT-1];
    assign tag_out    = tag_pipe[LAT-1];

    always_comb begin
        rsp_vld = '0;
        for (int t = 0; t < NREQ; t++)
            rsp_vld[t] = tagvld_out && (tag_out == TW'(t));
    end

    assign rsp_data = hd_dout;

    // Counts from the accepting cycle, so it includes the word sitting in hd_cin.
    always_comb begin
        inflight_nxt = inflight;
        if (xfer && !tagvld_out)
            inflight_nxt = inflight + IW'(1);
        else if (!xfer && tagvld_out)
            inflight_nxt = inflight - IW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            inflight <= '0;
        else
            inflight <= inflight_nxt;
    end

    // Looking at the post-retire count lets IDLE follow the last strobe by one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (drain) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (!drain)
                    state_nxt = S_RUN;
                else if (inflight_nxt == '0 && !hd_cvld)
                    state_nxt = S_IDLE;
            end
            S_IDLE:  if (!drain) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_RUN;
        else
            state <= state_nxt;
    end

    assign idle = (state == S_IDLE);

    // Decoder output is untrusted for LAT+1 cycles after reset (stale or unknown).
    assign chk_en = (mask_cnt == IW'(LAT + 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_cnt <= '0;
            seq_err  <= 1'b0;
        end else begin
            if (!chk_en)
                mask_cnt <= mask_cnt + IW'(1);
            if (chk_en && (hd_dvld != tagvld_out))
                seq_err <= 1'b1;
        end
    end

`ifdef HD_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stat_cnt <= '0;
        else if (state == S_IDLE && state_nxt == S_RUN)
            stat_cnt <= '0;
        else if (tagvld_out && stat_cnt != 16'hFFFF)
            stat_cnt <= stat_cnt + 16'd1;
    end
`else
    // No response statistics in this build.
`endif

endmodule

// File: tb/tb_hd_arb.sv
// Directed bench for hd_arb: a fixed-latency decoder stand-in returns the low K bits of each codeword.
module tb_hd_arb;
    localparam int K    = 8;
    localparam int NREQ = 4;
    localparam int LAT  = 4;
    localparam int CW   = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_vld = '0;
    logic [NREQ-1:0]   req_rdy;
    logic [NREQ*CW-1:0] req_cw = '0;
    logic [CW-1:0]     hd_cin;
    logic              hd_cvld;
    logic [K-1:0]      hd_dout;
    logic              hd_dvld;
    logic [NREQ-1:0]   rsp_vld;
    logic [K-1:0]      rsp_data;
    logic              drain = 1'b0;
    logic              idle;
    logic              seq_err;
`ifdef HD_ARB_STATS_EN
    logic [15:0]       stat_cnt;
`endif

    logic              force_dvld = 1'b0;
    logic [LAT-1:0]    dec_v = '0;
    logic [K-1:0]      dec_d [LAT];

    int checks = 0;
    int errors = 0;

    hd_arb #(.K(K), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_cw(req_cw),
        .hd_cin(hd_cin), .hd_cvld(hd_cvld), .hd_dout(hd_dout), .hd_dvld(hd_dvld),
        .rsp_vld(rsp_vld), .rsp_data(rsp_data),
        .drain(drain), .idle(idle), .seq_err(seq_err)
`ifdef HD_ARB_STATS_EN
        , .stat_cnt(stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Decoder stand-in: not reset by rst, so stale words can emerge after a reset.
    always @(posedge clk) begin
        dec_v    <= {dec_v[LAT-2:0], hd_cvld};
        dec_d[0] <= hd_cin[K-1:0];
        for (int s = 1; s < LAT; s++)
            dec_d[s] <= dec_d[s-1];
    end
    assign hd_dvld = dec_v[LAT-1] | force_dvld;
    assign hd_dout = dec_d[LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        repeat (LAT + 3) step();
    endtask

    task automatic test_reset();
        #1;
        rst = 1'b0;
        req_vld = 4'hF;
        #1;
        checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy got %b exp 0000", req_rdy); end
        checks++; if (hd_cvld !== 1'b0) begin errors++; $display("FAIL reset_cvld got %b exp 0", hd_cvld); end
        checks++; if (hd_cin !== 12'h000) begin errors++; $display("FAIL reset_cin got %h exp 000", hd_cin); end
        checks++; if (rsp_vld !== 4'b0000) begin errors++; $display("FAIL reset_rsp got %b exp 0000", rsp_vld); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL reset_idle got %b exp 0", idle); end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seqerr got %b exp 0", seq_err); end
        step();
        step();
        #1;
        checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy_clk got %b exp 0000", req_rdy); end
        checks++; if (hd_cvld !== 1'b0) begin errors++; $display("FAIL reset_cvld_clk got %b exp 0", hd_cvld); end
        rst = 1'b1;
        req_vld = 4'h0;
        repeat (LAT + 3) step();
        checks++; if (idle !== 1'b0 || seq_err !== 1'b0) begin errors++; $display("FAIL post_reset got idle=%b seq_err=%b exp 0 0", idle, seq_err); end
    endtask

    task automatic test_single();
        logic [3:0] exp_rsp;
        step();
        req_cw = '0;
        req_cw[2*CW +: CW] = 12'h0A5;
        req_vld = 4'b0100;
        #1;
        checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL single_rdy got %b exp 0100", req_rdy); end
        for (int c = 1; c <= 6; c++) begin
            step();
            req_vld = 4'b0000;
            #1;
            if (c == 1) begin
                checks++; if (hd_cvld !== 1'b1) begin errors++; $display("FAIL single_cvld got %b exp 1", hd_cvld); end
                checks++; if (hd_cin !== 12'h0A5) begin errors++; $display("FAIL single_cin got %h exp 0a5", hd_cin); end
            end
            if (c == 2) begin
                checks++; if (hd_cvld !== 1'b0) begin errors++; $display("FAIL single_cvld_drop got %b exp 0", hd_cvld); end
            end
            exp_rsp = (c == 5) ? 4'b0100 : 4'b0000;
            checks++; if (rsp_vld !== exp_rsp) begin errors++; $display("FAIL single_rsp c=%0d got %b exp %b", c, rsp_vld, exp_rsp); end
            if (c == 5) begin
                checks++; if (rsp_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", rsp_data); end
            end
        end
    endtask

    task automatic test_all4();
        logic [3:0] exp_rdy, exp_rsp;
        logic [7:0] exp_d;
        int peak;
        peak = 0;
        for (int i = 0; i < NREQ; i++)
            req_cw[i*CW +: CW] = {4'(i), 8'h30 + 8'(i)};
        for (int c = 0; c < 14; c++) begin
            step();
            req_vld = (c < 8) ? 4'hF : 4'h0;
            #1;
            exp_rdy = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            checks++; if (req_rdy !== exp_rdy) begin errors++; $display("FAIL all4_grant c=%0d got %b exp %b", c, req_rdy, exp_rdy); end
            exp_rsp = (c >= 5 && c < 13) ? (4'b0001 << ((c - 5) % 4)) : 4'b0000;
            checks++; if (rsp_vld !== exp_rsp) begin errors++; $display("FAIL all4_rsp c=%0d got %b exp %b", c, rsp_vld, exp_rsp); end
            if (exp_rsp != 4'b0000) begin
                exp_d = 8'h30 + 8'((c - 5) % 4);
                checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL all4_data c=%0d got %h exp %h", c, rsp_data, exp_d); end
            end
            if (int'(dut.inflight) > peak) peak = int'(dut.inflight);
        end
        checks++; if (peak != 5) begin errors++; $display("FAIL all4_inflight_peak got %0d exp 5", peak); end
    endtask

    task automatic test_fair();
        logic [3:0] exp_rdy, exp_rsp;
        for (int c = 0; c < 14; c++) begin
            step();
            req_vld = (c < 8) ? 4'b1001 : 4'b0000;
            #1;
            exp_rdy = (c >= 8) ? 4'b0000 : ((c % 2 == 0) ? 4'b0001 : 4'b1000);
            checks++; if (req_rdy !== exp_rdy) begin errors++; $display("FAIL fair_grant c=%0d got %b exp %b", c, req_rdy, exp_rdy); end
            exp_rsp = (c < 5 || c >= 13) ? 4'b0000 : (((c - 5) % 2 == 0) ? 4'b0001 : 4'b1000);
            checks++; if (rsp_vld !== exp_rsp) begin errors++; $display("FAIL fair_rsp c=%0d got %b exp %b", c, rsp_vld, exp_rsp); end
        end
    endtask

    task automatic test_drain();
        logic [3:0] exp_rdy, exp_rsp;
        logic       exp_idle;
        for (int c = 0; c < 13; c++) begin
            step();
            req_vld = 4'hF;
            drain = (c >= 3 && c <= 9);
            #1;
            if (c < 3)       exp_rdy = 4'b0001 << c;
            else if (c == 11) exp_rdy = 4'b1000;
            else if (c == 12) exp_rdy = 4'b0001;
            else             exp_rdy = 4'b0000;
            checks++; if (req_rdy !== exp_rdy) begin errors++; $display("FAIL drain_grant c=%0d got %b exp %b", c, req_rdy, exp_rdy); end
            exp_rsp = (c >= 5 && c <= 7) ? (4'b0001 << (c - 5)) : 4'b0000;
            checks++; if (rsp_vld !== exp_rsp) begin errors++; $display("FAIL drain_rsp c=%0d got %b exp %b", c, rsp_vld, exp_rsp); end
            exp_idle = (c >= 8 && c <= 10);
            checks++; if (idle !== exp_idle) begin errors++; $display("FAIL drain_idle c=%0d got %b exp %b", c, idle, exp_idle); end
        end
        req_vld = 4'h0;
        drain = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            step();
            req_vld = 4'hF;
        end
        step();
        rst = 1'b0;
        #1;
        checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL mid_rdy got %b exp 0000", req_rdy); end
        checks++; if (hd_cvld !== 1'b0 || hd_cin !== 12'h000) begin errors++; $display("FAIL mid_launch got cvld=%b cin=%h exp 0 000", hd_cvld, hd_cin); end
        checks++; if (rsp_vld !== 4'b0000) begin errors++; $display("FAIL mid_rsp got %b exp 0000", rsp_vld); end
        checks++; if (idle !== 1'b0 || seq_err !== 1'b0) begin errors++; $display("FAIL mid_flags got idle=%b seq_err=%b exp 0 0", idle, seq_err); end
        step();
        rst = 1'b1;
        req_vld = 4'h0;
        for (int c = 0; c < 12; c++) begin
            #1;
            checks++; if (rsp_vld !== 4'b0000) begin errors++; $display("FAIL mid_stale_rsp c=%0d got %b exp 0000", c, rsp_vld); end
            step();
        end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL mid_seqerr got %b exp 0", seq_err); end
    endtask

    task automatic test_mismatch();
        repeat (3) step();
        force_dvld = 1'b1;
        #1;
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL mm_pre got %b exp 0", seq_err); end
        step();
        force_dvld = 1'b0;
        #1;
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL mm_set got %b exp 1", seq_err); end
        repeat (5) step();
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL mm_sticky got %b exp 1", seq_err); end
        rst = 1'b0;
        #1;
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL mm_clear got %b exp 0", seq_err); end
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        do_reset();
        test_all4();
        test_fair();
        test_drain();
        test_reset_mid();
        test_mismatch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
